// File: rtl/seq_divider16by8.sv
// seq_divider16by8: iterative radix-2 restoring divider.
// Divides a 2N-bit dividend by an N-bit divisor and resolves one quotient bit
// per clock. The start/busy/valid handshake frames each division. A divisor
// of zero and a quotient too wide for N bits are both flagged, and each
// produces a saturated quotient.
module seq_divider16by8 #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             valid,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [N:0]    r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          pend_dz;
    logic          pend_ov;

    logic [N:0]    t;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;

    // One restoring step: shift in the next dividend bit, then subtract if it fits.
    always_comb begin
        t      = {r[N-1:0], q[N-1]};
        r_next = t;
        q_next = {q[N-2:0], 1'b0};
        if (t >= {1'b0, d}) begin
            r_next = t - {1'b0, d};
            q_next = {q[N-2:0], 1'b1};
        end
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            pend_dz   <= 1'b0;
            pend_ov   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        d     <= divisor;
                        busy  <= 1'b1;
                        state <= RUN;
                        if (divisor == '0) begin
                            pend_dz <= 1'b1;
                            pend_ov <= 1'b0;
                            r       <= '0;
                            q       <= '0;
                            cnt     <= '0;
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            pend_dz <= 1'b0;
                            pend_ov <= 1'b1;
                            r       <= '0;
                            q       <= '0;
                            cnt     <= '0;
                        end else begin
                            pend_dz <= 1'b0;
                            pend_ov <= 1'b0;
                            r       <= {1'b0, dividend[2*N-1:N]};
                            q       <= dividend[N-1:0];
                            cnt     <= CW'(N);
                        end
                    end
                end

                RUN: begin
                    // Error results spend one cycle here so their valid pulse
                    // lands one edge after the accept edge, like a one-step run.
                    if (pend_dz || pend_ov) begin
                        state     <= DONE;
                        valid     <= 1'b1;
                        div_zero  <= pend_dz;
                        overflow  <= pend_ov;
                        quotient  <= '1;
                        remainder <= '0;
                        pend_dz   <= 1'b0;
                        pend_ov   <= 1'b0;
                    end else begin
                        r   <= r_next;
                        q   <= q_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state     <= DONE;
                            valid     <= 1'b1;
                            quotient  <= q_next;
                            remainder <= r_next[N-1:0];
                            div_zero  <= 1'b0;
                            overflow  <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
